ib32bit_fetch_unit: RTL and testbench

//  Instruction-fetch front end for the 32-bit processor; consumer/producer partner of the PC register.

---
 rtl/ib32bit_pkg.sv | 37 +++
 rtl/ib32bit_fetch_fifo.sv | 95 +++++++++
 rtl/ib32bit_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_ib32bit_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ib32bit_pkg.sv
// ----------------------------------------------------------------------------
// ib32bit_pkg
// Shared types and constants for the 32-bit processor instruction-fetch front
// end: address/data widths, the fetch FSM state encoding, the buffered
// instruction entry and the PC increment helper.
// ----------------------------------------------------------------------------
package ib32bit_pkg;

    // Word-address width of PC / imem (64 words, wraps mod 2^AWIDTH).
    localparam int AWIDTH = 6;
    // Instruction width.
    localparam int DWIDTH = 32;

    // Fetch sequencer states.
    //   IDLE : nothing outstanding, waiting for buffer room
    //   REQ  : issuing a read this cycle
    //   WAIT : awaiting read data for a live request
    //   DROP : awaiting read data that belongs to a squashed request
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] instr;
    } fetch_entry_t;

    // Sequential PC step; wraps naturally at 2^AWIDTH.
    function automatic logic [AWIDTH-1:0] pc_incr(input logic [AWIDTH-1:0] pc);
        return pc + AWIDTH'(1'b1);
    endfunction

endpackage

// File: rtl/ib32bit_fetch_fifo.sv
// ----------------------------------------------------------------------------
// ib32bit_fetch_fifo
// Small synchronous FIFO of fetch_entry_t used as the instruction buffer.
// The head entry is read straight from storage registers, so there is no
// combinational path from i_data to o_head. Flush has priority over push/pop.
//
// Ports
//   clk      in   clock, all state on posedge
//   rst      in   synchronous active-high reset
//   i_push   in   write i_data at the tail (caller guarantees not full)
//   i_pop    in   drop the head entry (caller guarantees not empty)
//   i_flush  in   empty the buffer; same-cycle push/pop are ignored
//   i_data   in   entry to push
//   o_head   out  oldest entry
//   o_count  out  number of valid entries
//   o_empty  out  buffer holds no entries
// ----------------------------------------------------------------------------
module ib32bit_fetch_fifo
    import ib32bit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic                           i_flush,
    input  fetch_entry_t                   i_data,
    output fetch_entry_t                   o_head,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W-1:0] w_wr_ptr_nxt;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    always_comb begin
        if (r_rd_ptr == PTR_W'(DEPTH - 1)) begin
            w_rd_ptr_nxt = '0;
        end else begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1'b1);
        end
        if (r_wr_ptr == PTR_W'(DEPTH - 1)) begin
            w_wr_ptr_nxt = '0;
        end else begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1'b1);
        end
    end

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= w_wr_ptr_nxt;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1'b1);
                2'b01:   r_count <= r_count - CNT_W'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == CNT_W'(1'b0));

endmodule

// File: rtl/ib32bit_fetch_unit.sv
// ----------------------------------------------------------------------------
// ib32bit_fetch_unit
// Instruction-fetch front end. Reads the current PC from the PC register,
// drives its next value, issues single-word reads to imem (at most one
// outstanding), buffers returned instructions with their PC and presents them
// to decode over valid/ready. A taken branch/jump from execute redirects the
// PC, flushes the buffer and squashes any read still in flight.
//
// Ports
//   clk          in   clock, all state on posedge
//   rst          in   synchronous active-high reset, overrides everything
//   pc_q         in   current PC (PC register output)
//   pc_next      out  next PC (PC register input), combinational
//   imem_req     out  one-cycle read request
//   imem_addr    out  read address, valid with imem_req
//   imem_rvalid  in   read data valid, at least one cycle after imem_req
//   imem_rdata   in   read data
//   redirect     in   branch/jump taken, one-cycle pulse
//   redirect_pc  in   target PC, valid with redirect
//   if_valid     out  instruction available to decode
//   if_ready     in   decode accepts
//   if_instr     out  instruction at buffer head
//   if_pc        out  PC of if_instr
// ----------------------------------------------------------------------------
module ib32bit_fetch_unit
    import ib32bit_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] pc_q,
    output logic [AWIDTH-1:0] pc_next,
    output logic              imem_req,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DWIDTH-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DWIDTH-1:0] if_instr,
    output logic [AWIDTH-1:0] if_pc
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t      r_state;
    logic [AWIDTH-1:0] r_saved_addr;

    fetch_entry_t      w_push_data;
    fetch_entry_t      w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_outstanding;
    logic [CNT_W:0]    w_occ;
    logic [CNT_W:0]    w_occ_after;
    logic              w_room;
    logic              w_room_after;

    // Buffer handshakes. A redirect squashes the returning data, and the
    // flush inside the FIFO already overrides any same-cycle pop.
    always_comb begin
        w_pop             = if_valid && if_ready;
        w_push            = (r_state == WAIT) && imem_rvalid && !redirect;
        w_push_data.pc    = r_saved_addr;
        w_push_data.instr = imem_rdata;
    end

    // Room reservation: an outstanding read owns a buffer slot so that its
    // data can always be accepted. w_room_after is the view once this
    // cycle's return has landed and any pop has left (used from WAIT only).
    always_comb begin
        w_outstanding = (r_state == WAIT) || (r_state == DROP);
        w_occ         = {1'b0, w_count} + {{CNT_W{1'b0}}, w_outstanding};
        w_occ_after   = {1'b0, w_count} + (CNT_W+1)'(1'b1) - {{CNT_W{1'b0}}, w_pop};
        w_room        = (w_occ < (CNT_W+1)'(BUF_DEPTH));
        w_room_after  = (w_occ_after < (CNT_W+1)'(BUF_DEPTH));
    end

    // Fetch sequencer and saved request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_saved_addr <= '0;
        end else if (redirect) begin
            // Anything in flight belongs to the old path; restart at the target.
            case (r_state)
                IDLE: begin
                    r_state      <= REQ;
                    r_saved_addr <= r_saved_addr;
                end
                REQ: begin
                    // The read still goes out this cycle; its data must be dropped.
                    r_state      <= DROP;
                    r_saved_addr <= pc_q;
                end
                WAIT: begin
                    r_state      <= imem_rvalid ? REQ : DROP;
                    r_saved_addr <= r_saved_addr;
                end
                DROP: begin
                    r_state      <= imem_rvalid ? REQ : DROP;
                    r_saved_addr <= r_saved_addr;
                end
                default: begin
                    r_state      <= IDLE;
                    r_saved_addr <= r_saved_addr;
                end
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    r_state      <= w_room ? REQ : IDLE;
                    r_saved_addr <= r_saved_addr;
                end
                REQ: begin
                    r_state      <= WAIT;
                    r_saved_addr <= pc_q;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= w_room_after ? REQ : IDLE;
                    end else begin
                        r_state <= WAIT;
                    end
                    r_saved_addr <= r_saved_addr;
                end
                DROP: begin
                    r_state      <= imem_rvalid ? REQ : DROP;
                    r_saved_addr <= r_saved_addr;
                end
                default: begin
                    r_state      <= IDLE;
                    r_saved_addr <= r_saved_addr;
                end
            endcase
        end
    end

    // Read request and next-PC selection; the PC only advances on the cycle
    // a request is issued, so it always names the next word to fetch.
    always_comb begin
        imem_req = !rst && (r_state == REQ);
        if (imem_req) begin
            imem_addr = pc_q;
        end else begin
            imem_addr = '0;
        end
        if (rst) begin
            pc_next = '0;
        end else if (redirect) begin
            pc_next = redirect_pc;
        end else if (r_state == REQ) begin
            pc_next = pc_incr(pc_q);
        end else begin
            pc_next = pc_q;
        end
    end

    ib32bit_fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign if_valid = !w_empty;
    assign if_instr = w_head.instr;
    assign if_pc    = w_head.pc;

endmodule

// File: tb/tb_ib32bit_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ib32bit_fetch_unit
// Directed bench for ib32bit_fetch_unit. Models the PC register and a
// fixed-latency imem that returns 0xA000_0000 + address, records every
// instruction accepted by decode and every request issued, and compares
// against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_ib32bit_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  pc_q;
    logic [5:0]  pc_next;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [5:0]  redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [5:0]  if_pc;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 1;
    int          pend_cnt = 0;
    logic [5:0]  pend_addr = 6'd0;
    int          req_cnt  = 0;
    logic [5:0]  acc_pc[$];
    logic [31:0] acc_instr[$];

    ib32bit_fetch_unit #(.BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_q        (pc_q),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    always #5 clk = ~clk;

    // PC register partner.
    always @(posedge clk) pc_q <= pc_next;

    // Fixed-latency imem; not reset, so a late return can land during rst.
    always @(posedge clk) begin
        if (imem_req) begin
            pend_cnt  <= lat;
            pend_addr <= imem_addr;
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end
    assign imem_rvalid = (pend_cnt == 1);
    assign imem_rdata  = 32'hA000_0000 | {26'd0, pend_addr};

    // Record accepted instructions and issued requests mid-cycle.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (if_valid && if_ready) begin
                acc_pc.push_back(if_pc);
                acc_instr.push_back(if_instr);
            end
            if (imem_req) req_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] get_pc(input int i);
        if (i < acc_pc.size()) return {26'd0, acc_pc[i]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] get_instr(input int i);
        if (i < acc_instr.size()) return acc_instr[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset(input logic ready, input int latency);
        @(negedge clk);
        rst      = 1'b1;
        redirect = 1'b0;
        if_ready = ready;
        lat      = latency;
        repeat (3) @(negedge clk);
        acc_pc.delete();
        acc_instr.delete();
        req_cnt = 0;
        rst     = 1'b0;
    endtask

    // Advance to the next negedge with imem_req at addr (any addr if any_addr).
    task automatic wait_req(input string tag, input int budget, input bit any_addr,
                            input logic [5:0] addr);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (imem_req && (any_addr || imem_addr == addr)) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (if_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 6'd0;
        if_ready    = 1'b0;

        // 1: reset values, then first request right after release.
        repeat (3) @(negedge clk);
        check_eq("rst_imem_req",  {31'd0, imem_req}, 32'd0);
        check_eq("rst_imem_addr", {26'd0, imem_addr}, 32'd0);
        check_eq("rst_if_valid",  {31'd0, if_valid}, 32'd0);
        check_eq("rst_if_instr",  if_instr, 32'd0);
        check_eq("rst_if_pc",     {26'd0, if_pc}, 32'd0);
        check_eq("rst_pc_next",   {26'd0, pc_next}, 32'd0);
        if_ready = 1'b1;
        rst      = 1'b0;
        @(negedge clk);
        check_eq("t1_imem_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t1_imem_addr", {26'd0, imem_addr}, 32'd0);
        check_eq("t1_pc_next",   {26'd0, pc_next}, 32'd1);

        // 2: streaming with 1-cycle imem, in order, no loss/duplication.
        repeat (10) @(negedge clk);
        check_eq("t2_count_ge3", {31'd0, acc_pc.size() >= 3}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_pc",    get_pc(i), i);
            check_eq("t2_instr", get_instr(i), 32'hA000_0000 + i);
        end

        // 3: decode stalled -> exactly two entries buffered, then resume at 2.
        do_reset(1'b0, 1);
        repeat (12) @(negedge clk);
        check_eq("t3_req_cnt",  req_cnt, 32'd2);
        check_eq("t3_imem_req", {31'd0, imem_req}, 32'd0);
        check_eq("t3_if_valid", {31'd0, if_valid}, 32'd1);
        check_eq("t3_if_pc",    {26'd0, if_pc}, 32'd0);
        check_eq("t3_if_instr", if_instr, 32'hA000_0000);
        check_eq("t3_pc_q",     {26'd0, pc_q}, 32'd2);
        if_ready = 1'b1;
        wait_req("t3_req_timeout", 6, 1'b1, 6'd0);
        check_eq("t3_next_addr", {26'd0, imem_addr}, 32'd2);
        check_eq("t3_acc_size",  acc_pc.size(), 32'd2);
        check_eq("t3_acc0",      get_pc(0), 32'd0);
        check_eq("t3_acc1",      get_pc(1), 32'd1);

        // 4: latency 3, redirect to 0x20 the cycle after the req for addr 5.
        do_reset(1'b1, 3);
        wait_req("t4_req5_timeout", 60, 1'b0, 6'd5);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 6'h20;
        #1;
        check_eq("t4_pc_next_redir", {26'd0, pc_next}, 32'h20);
        @(negedge clk);
        redirect = 1'b0;
        check_eq("t4_flushed", {31'd0, if_valid}, 32'd0);
        check_eq("t4_pc_q",    {26'd0, pc_q}, 32'h20);
        wait_req("t4_req20_timeout", 10, 1'b1, 6'd0);
        check_eq("t4_next_addr", {26'd0, imem_addr}, 32'h20);
        check_eq("t4_no_stale",  {31'd0, if_valid}, 32'd0);
        wait_valid("t4_valid_timeout", 10);
        check_eq("t4_if_pc",    {26'd0, if_pc}, 32'h20);
        check_eq("t4_if_instr", if_instr, 32'hA000_0020);
        check_eq("t4_acc_size", acc_pc.size(), 32'd5);
        check_eq("t4_acc_last", get_pc(4), 32'd4);

        // 5: PC wrap 0x3F -> 0x00 with sequential if_pc across it.
        do_reset(1'b1, 1);
        wait_req("t5_req3f_timeout", 200, 1'b0, 6'h3F);
        check_eq("t5_pc_next_wrap", {26'd0, pc_next}, 32'd0);
        wait_req("t5_req0_timeout", 6, 1'b1, 6'd0);
        check_eq("t5_wrap_addr", {26'd0, imem_addr}, 32'd0);
        repeat (4) @(negedge clk);
        check_eq("t5_acc_ge65", {31'd0, acc_pc.size() >= 65}, 32'd1);
        for (int i = 0; i < acc_pc.size(); i++) begin
            check_eq("t5_seq_pc",    get_pc(i), i % 64);
            check_eq("t5_seq_instr", get_instr(i), 32'hA000_0000 + (i % 64));
        end

        // 6: reset while waiting; late rvalid during rst must be ignored.
        do_reset(1'b1, 3);
        wait_req("t6_req_timeout", 10, 1'b1, 6'd0);
        check_eq("t6_first_addr", {26'd0, imem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6_rst_if_valid", {31'd0, if_valid}, 32'd0);
        check_eq("t6_rst_imem_req", {31'd0, imem_req}, 32'd0);
        check_eq("t6_rst_pc_next",  {26'd0, pc_next}, 32'd0);
        acc_pc.delete();
        acc_instr.delete();
        rst = 1'b0;
        wait_req("t6_restart_timeout", 6, 1'b1, 6'd0);
        check_eq("t6_restart_addr", {26'd0, imem_addr}, 32'd0);
        check_eq("t6_no_stale",     {31'd0, if_valid}, 32'd0);
        wait_valid("t6_valid_timeout", 10);
        check_eq("t6_if_pc",    {26'd0, if_pc}, 32'd0);
        check_eq("t6_if_instr", if_instr, 32'hA000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
